// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the accumulator processor front end:
//   - opcode encodings (4-bit, instruction bits [8:5])
//   - instruction field slice positions
//   - fetch FSM state type
//   - default contents of the 16-entry branch target table
//   - helper that resolves whether a lookup branch is taken
// ----------------------------------------------------------------------------
package proc_pkg;

    // Instruction field positions within the 9-bit instruction word.
    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned ID_BIT  = 4;
    localparam int unsigned OPR_MSB = 3;
    localparam int unsigned OPR_LSB = 0;

    // Branch target table geometry. Default entries are stored at the
    // maximum program-counter width and resized to PC_W where used.
    localparam int unsigned LUT_ENTRIES = 16;
    localparam int unsigned LUT_ADDR_W  = 4;
    localparam int unsigned LUT_DEF_W   = 10;

    // Opcode encodings.
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_LOADI = 4'b1010;
    localparam logic [3:0] OP_NOP   = 4'b1011;
    localparam logic [3:0] OP_BR    = 4'b1100;
    localparam logic [3:0] OP_BRZ   = 4'b1101;
    localparam logic [3:0] OP_BRN   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Power-on / reset contents of the branch target table.
    localparam logic [LUT_DEF_W-1:0] BR_LUT_DEFAULT [LUT_ENTRIES] = '{
        10'd0,   10'd10,  10'd16,  10'd20,
        10'd32,  10'd40,  10'd48,  10'd56,
        10'd64,  10'd72,  10'd80,  10'd96,
        10'd128, 10'd256, 10'd512, 10'd1000
    };

    // Taken condition of a lookup branch given its opcode and the
    // accumulator flags; non-branch opcodes are never taken.
    function automatic logic branch_taken(
        input logic [3:0] opc,
        input logic       az,
        input logic       an
    );
        case (opc)
            OP_BR:   return 1'b1;
            OP_BRZ:  return az;
            OP_BRN:  return an;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_lut.sv
// ----------------------------------------------------------------------------
// branch_lut
// 16 x PC_W branch target table, read combinationally by the instruction
// operand.
//
// Optional build macro LUT_WRITE_EN:
//   undefined - table is the constant BR_LUT_DEFAULT contents, read-only.
//   defined   - table is a register file loaded with BR_LUT_DEFAULT on reset
//               and written synchronously through we/waddr/wdata. The caller
//               is responsible for qualifying we. A read of the entry being
//               written in the same cycle returns the old value.
//
// Ports:
//   clk, rst  (LUT_WRITE_EN only) clock, async active-high reset
//   we        (LUT_WRITE_EN only) write enable
//   waddr     (LUT_WRITE_EN only) entry to write
//   wdata     (LUT_WRITE_EN only) new target value
//   raddr     entry to read (instruction operand)
//   rdata     branch target at raddr
// ----------------------------------------------------------------------------
module branch_lut
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = 10
) (
`ifdef LUT_WRITE_EN
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [LUT_ADDR_W-1:0] waddr,
    input  logic [PC_W-1:0]       wdata,
`endif
    input  logic [LUT_ADDR_W-1:0] raddr,
    output logic [PC_W-1:0]       rdata
);

`ifdef LUT_WRITE_EN

    logic [PC_W-1:0] tbl [LUT_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LUT_ENTRIES; i++) begin
                tbl[i] <= PC_W'(BR_LUT_DEFAULT[i]);
            end
        end else if (we) begin
            tbl[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = tbl[raddr];
    end

`else

    always_comb begin
        rdata = PC_W'(BR_LUT_DEFAULT[raddr]);
    end

`endif

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Front end of the accumulator processor: owns the program counter, splits
// the current instruction into fields for the control decoder, and runs the
// Start/Done handshake with the environment.
//
// Sequencer: IDLE -> RUN (first cycle with Start low) -> HALT (halt decode
// or PC past last address) -> IDLE (Start high). Start high while running
// aborts back to IDLE; the instruction in flight that cycle still retires.
//
// Optional build macro LUT_WRITE_EN adds lut_we/lut_waddr/lut_wdata to
// rewrite the branch target table; writes only take effect in IDLE.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   Start        start / abort request
//   instr_in     instruction ROM data at prog_ctr
//   Branch       decoder: current instruction is a branch
//   Lookup       decoder: branch target comes from the lookup table
//   DoneIn       decoder: current instruction is halt
//   acc_zero     accumulator == 0
//   acc_neg      accumulator MSB
//   lut_we       (LUT_WRITE_EN) table write enable
//   lut_waddr    (LUT_WRITE_EN) table write address
//   lut_wdata    (LUT_WRITE_EN) table write data
//   prog_ctr     ROM address
//   opcode       instr_in[8:5]
//   identifier   instr_in[4]
//   operand      instr_in[3:0]
//   instr_valid  high only in RUN; qualifies downstream write enables
//   Done         program finished, held until next Start
//   pc_overflow  sticky: PC ran past the last address
//   instr_count  instructions retired this run, saturating
// ----------------------------------------------------------------------------
module instr_fetch
    import proc_pkg::*;
#(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic                  Branch,
    input  logic                  Lookup,
    input  logic                  DoneIn,
    input  logic                  acc_zero,
    input  logic                  acc_neg,
`ifdef LUT_WRITE_EN
    input  logic                  lut_we,
    input  logic [LUT_ADDR_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]       lut_wdata,
`endif
    output logic [PC_W-1:0]       prog_ctr,
    output logic [3:0]            opcode,
    output logic                  identifier,
    output logic [3:0]            operand,
    output logic                  instr_valid,
    output logic                  Done,
    output logic                  pc_overflow,
    output logic [CNT_W-1:0]      instr_count
);

    fetch_state_t     state;
    fetch_state_t     state_nx;
    logic [PC_W-1:0]  pc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_set;
    logic [PC_W-1:0]  lut_target;
    logic             pc_last;
    logic             take_branch;

    // ------------------------------------------------------------------
    // Instruction fields: zero-latency slices of the ROM data.
    // ------------------------------------------------------------------
    always_comb begin
        opcode     = instr_in[OPC_MSB:OPC_LSB];
        identifier = instr_in[ID_BIT];
        operand    = instr_in[OPR_MSB:OPR_LSB];
    end

    // ------------------------------------------------------------------
    // Branch target table, addressed by the operand field.
    // ------------------------------------------------------------------
`ifdef LUT_WRITE_EN
    logic lut_we_q;

    // Table is only writable while the sequencer is idle.
    always_comb begin
        lut_we_q = lut_we && (state == IDLE);
    end

    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .clk   (Clk),
        .rst   (Reset),
        .we    (lut_we_q),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (operand),
        .rdata (lut_target)
    );
`else
    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .raddr (operand),
        .rdata (lut_target)
    );
`endif

    always_comb begin
        pc_last     = &prog_ctr;
        take_branch = Branch && Lookup && branch_taken(opcode, acc_zero, acc_neg);
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC logic.
    // Priority in RUN: abort (Start) > halt decode > taken lookup branch >
    // sequential. Sequential past the last address halts instead of
    // wrapping. Entering IDLE clears the PC and retire count so IDLE
    // always presents address 0.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        pc_nx       = prog_ctr;
        cnt_nx      = instr_count;
        ovf_set     = 1'b0;
        instr_valid = 1'b0;
        Done        = 1'b0;

        unique case (state)
            IDLE: begin
                pc_nx  = '0;
                cnt_nx = '0;
                if (!Start) begin
                    state_nx = RUN;
                end
            end

            RUN: begin
                instr_valid = 1'b1;
                if (!(&instr_count)) begin
                    cnt_nx = instr_count + CNT_W'(1);
                end

                if (Start) begin
                    state_nx = IDLE;
                    pc_nx    = '0;
                    cnt_nx   = '0;
                end else if (DoneIn) begin
                    state_nx = HALT;
                end else if (take_branch) begin
                    pc_nx = lut_target;
                end else if (pc_last) begin
                    state_nx = HALT;
                    ovf_set  = 1'b1;
                end else begin
                    pc_nx = prog_ctr + PC_W'(1);
                end
            end

            HALT: begin
                Done = 1'b1;
                if (Start) begin
                    state_nx = IDLE;
                    pc_nx    = '0;
                    cnt_nx   = '0;
                end
            end

            default: begin
                state_nx = IDLE;
                pc_nx    = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, program counter, retire counter, overflow flag.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            instr_count <= '0;
            pc_overflow <= 1'b0;
        end else begin
            state       <= state_nx;
            prog_ctr    <= pc_nx;
            instr_count <= cnt_nx;
            if (ovf_set) begin
                pc_overflow <= 1'b1;
            end
        end
    end

endmodule
